// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: N coin denominations, overpay credit carry,
// cancel/refund and a valid/ready change handshake.
// Optional feature macro: VEND_SALES_CNT_EN adds the sales_cnt port and counter.
module vending_fsm_param #(
    parameter int unsigned                     NUM_COINS = 3,
    parameter int unsigned                     CREDIT_W  = 8,
    parameter int unsigned                     PRICE     = 5,
    parameter logic [NUM_COINS*CREDIT_W-1:0]   COIN_VALS = {8'd5, 8'd2, 8'd1}
`ifdef VEND_SALES_CNT_EN
    ,
    parameter int unsigned                     SALES_W   = 16
`endif
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         coin_valid,
    input  logic [((NUM_COINS > 1) ? $clog2(NUM_COINS) : 1)-1:0] coin_sel,
    output logic                                         coin_ready,
    output logic                                         coin_reject,
    input  logic                                         cancel,
    output logic                                         dispense,
    output logic [CREDIT_W-1:0]                          credit,
    output logic                                         change_valid,
    output logic [CREDIT_W-1:0]                          change_amt,
    input  logic                                         change_ready
`ifdef VEND_SALES_CNT_EN
    ,
    output logic [SALES_W-1:0]                           sales_cnt
`endif
);

    localparam int unsigned SEL_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

    // Largest denomination, used to check that credit arithmetic cannot wrap.
    function automatic longint unsigned max_coin_f();
        longint unsigned m;
        m = 0;
        for (int i = 0; i < int'(NUM_COINS); i++) begin
            if (longint'(COIN_VALS[i*CREDIT_W +: CREDIT_W]) > m) begin
                m = longint'(COIN_VALS[i*CREDIT_W +: CREDIT_W]);
            end
        end
        return m;
    endfunction

    localparam longint unsigned MAX_COIN = max_coin_f();
    localparam longint unsigned CRED_MAX = (64'd1 << CREDIT_W) - 64'd1;

    // Elaboration-time parameter sanity checks.
    if (PRICE < 1) begin : g_price_chk
        $error("vending_fsm_param: PRICE must be >= 1");
    end
    if (longint'(PRICE) + MAX_COIN - 64'd1 > CRED_MAX) begin : g_credit_w_chk
        $error("vending_fsm_param: CREDIT_W too narrow for PRICE + max coin - 1");
    end

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_VEND    = 2'd1,
        S_CHANGE  = 2'd2
    } state_e;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_e                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  dispense_q, dispense_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]   change_amt_q, change_amt_d;
`ifdef VEND_SALES_CNT_EN
    logic [SALES_W-1:0]    sales_cnt_q, sales_cnt_d;
`endif

    logic                  in_collect;
    logic                  coin_acc;
    logic                  coin_hit;
    logic                  coin_ok;
    logic                  refund;
    logic [CREDIT_W-1:0]   coin_val;
    logic [CREDIT_W-1:0]   sum;

    // Denomination lookup; out-of-range selects leave coin_hit low.
    always_comb begin
        coin_hit = 1'b0;
        coin_val = '0;
        for (int i = 0; i < int'(NUM_COINS); i++) begin
            if (SEL_W'(i) == coin_sel) begin
                coin_hit = 1'b1;
                coin_val = COIN_VALS[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    assign in_collect = (state_q == S_COLLECT);
    assign coin_acc   = coin_valid & in_collect;
    assign coin_ok    = coin_acc & coin_hit;
    assign sum        = credit_q + (coin_ok ? coin_val : '0);
    assign refund     = in_collect & cancel & ((credit_q != '0) | coin_ok);

    // State register plus registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_COLLECT;
            credit_q       <= '0;
            dispense_q     <= 1'b0;
            coin_reject_q  <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
`ifdef VEND_SALES_CNT_EN
            sales_cnt_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            dispense_q     <= dispense_d;
            coin_reject_q  <= coin_reject_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
`ifdef VEND_SALES_CNT_EN
            sales_cnt_q    <= sales_cnt_d;
`endif
        end
    end

    // Next-state logic; refund takes priority over completing a sale.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: begin
                if (refund) begin
                    state_d = S_CHANGE;
                end else if (coin_ok && (sum >= PRICE_C)) begin
                    state_d = S_VEND;
                end
            end
            S_VEND:   state_d = (credit_q != '0) ? S_CHANGE : S_COLLECT;
            S_CHANGE: if (change_ready) state_d = S_COLLECT;
            default:  state_d = S_COLLECT;
        endcase
    end

    // Next values of credit and registered outputs.
    always_comb begin
        credit_d       = credit_q;
        dispense_d     = 1'b0;
        coin_reject_d  = 1'b0;
        change_valid_d = change_valid_q;
        change_amt_d   = change_amt_q;
`ifdef VEND_SALES_CNT_EN
        sales_cnt_d    = dispense_q ? (sales_cnt_q + SALES_W'(1)) : sales_cnt_q;
`endif
        case (state_q)
            S_COLLECT: begin
                coin_reject_d = coin_acc & ~coin_hit;
                if (refund) begin
                    change_valid_d = 1'b1;
                    change_amt_d   = sum;
                    credit_d       = sum;
                end else if (coin_ok) begin
                    if (sum >= PRICE_C) begin
                        dispense_d = 1'b1;
                        credit_d   = sum - PRICE_C;
                    end else begin
                        credit_d   = sum;
                    end
                end
            end
            S_VEND: begin
                if (credit_q != '0) begin
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q;
                end
            end
            S_CHANGE: begin
                if (change_ready) begin
                    credit_d       = '0;
                    change_valid_d = 1'b0;
                end
            end
            default: begin
                credit_d       = '0;
                change_valid_d = 1'b0;
            end
        endcase
    end

    assign coin_ready   = in_collect;
    assign coin_reject  = coin_reject_q;
    assign dispense     = dispense_q;
    assign credit       = credit_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
`ifdef VEND_SALES_CNT_EN
    assign sales_cnt    = sales_cnt_q;
`endif

endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed bench for vending_fsm_param at default parameters
// (PRICE=5, coin idx0=1, idx1=2, idx2=5).
module tb_vending_fsm_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       coin_ready;
    logic       coin_reject;
    logic       cancel;
    logic       dispense;
    logic [7:0] credit;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       change_ready;
`ifdef VEND_SALES_CNT_EN
    logic [15:0] sales_cnt;
`endif

    int nvec  = 0;
    int nfail = 0;

    vending_fsm_param dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .coin_valid   (coin_valid),
        .coin_sel     (coin_sel),
        .coin_ready   (coin_ready),
        .coin_reject  (coin_reject),
        .cancel       (cancel),
        .dispense     (dispense),
        .credit       (credit),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .change_ready (change_ready)
`ifdef VEND_SALES_CNT_EN
        ,
        .sales_cnt    (sales_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [1:0] sel);
        coin_valid = 1'b1;
        coin_sel   = sel;
        step();
        coin_valid = 1'b0;
        coin_sel   = 2'd0;
    endtask

    initial begin
        reset_n      = 1'b0;
        coin_valid   = 1'b0;
        coin_sel     = 2'd0;
        cancel       = 1'b0;
        change_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;

        // Reset state
        chk("rst_credit",   32'(credit), 0);
        chk("rst_dispense", 32'(dispense), 0);
        chk("rst_reject",   32'(coin_reject), 0);
        chk("rst_chg_v",    32'(change_valid), 0);
        chk("rst_chg_amt",  32'(change_amt), 0);
        chk("rst_ready",    32'(coin_ready), 1);
`ifdef VEND_SALES_CNT_EN
        chk("rst_sales",    32'(sales_cnt), 0);
`endif

        // 1: 1+2+2 exact price
        coin(2'd0);
        chk("t1_credit1", 32'(credit), 1);
        chk("t1_disp1",   32'(dispense), 0);
        coin(2'd1);
        chk("t1_credit3", 32'(credit), 3);
        coin(2'd1);
        chk("t1_disp",    32'(dispense), 1);
        chk("t1_credit0", 32'(credit), 0);
        chk("t1_ready0",  32'(coin_ready), 0);
        step();
        chk("t1_disp_off", 32'(dispense), 0);
        chk("t1_chg_v",    32'(change_valid), 0);
        chk("t1_ready1",   32'(coin_ready), 1);
`ifdef VEND_SALES_CNT_EN
        chk("t1_sales",    32'(sales_cnt), 1);
`endif

        // 2: single 5 coin
        coin(2'd2);
        chk("t2_disp",   32'(dispense), 1);
        chk("t2_credit", 32'(credit), 0);
        step();
        chk("t2_disp_off", 32'(dispense), 0);
        chk("t2_chg_v",    32'(change_valid), 0);
`ifdef VEND_SALES_CNT_EN
        chk("t2_sales",    32'(sales_cnt), 2);
`endif

        // 3: 2+2+2 overpay, change handshake held off
        coin(2'd1);
        coin(2'd1);
        chk("t3_credit4", 32'(credit), 4);
        coin(2'd1);
        chk("t3_disp",    32'(dispense), 1);
        chk("t3_credit1", 32'(credit), 1);
        chk("t3_chg_v0",  32'(change_valid), 0);
        step();
        chk("t3_chg_v",   32'(change_valid), 1);
        chk("t3_chg_amt", 32'(change_amt), 1);
        chk("t3_disp_off", 32'(dispense), 0);
        for (int i = 0; i < 3; i++) begin
            cancel     = (i == 1);
            coin_valid = (i == 2);
            step();
            chk("t3_hold_amt",   32'(change_amt), 1);
            chk("t3_hold_v",     32'(change_valid), 1);
            chk("t3_hold_ready", 32'(coin_ready), 0);
        end
        cancel       = 1'b0;
        coin_valid   = 1'b0;
        change_ready = 1'b1;
        step();
        change_ready = 1'b0;
        chk("t3_done_v",      32'(change_valid), 0);
        chk("t3_done_credit", 32'(credit), 0);
        chk("t3_done_ready",  32'(coin_ready), 1);

        // 4: cancel after a coin, and coin+cancel in the same cycle
        coin(2'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("t4_chg_v",   32'(change_valid), 1);
        chk("t4_chg_amt", 32'(change_amt), 2);
        chk("t4_disp",    32'(dispense), 0);
        change_ready = 1'b1;
        step();
        change_ready = 1'b0;
        chk("t4_done_v",      32'(change_valid), 0);
        chk("t4_done_credit", 32'(credit), 0);
        coin_valid = 1'b1;
        coin_sel   = 2'd0;
        cancel     = 1'b1;
        step();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        chk("t4b_chg_v",   32'(change_valid), 1);
        chk("t4b_chg_amt", 32'(change_amt), 1);
        chk("t4b_disp",    32'(dispense), 0);
        change_ready = 1'b1;
        step();
        change_ready = 1'b0;
        chk("t4b_done_v", 32'(change_valid), 0);

        // 5: invalid coin select, then cancel at zero credit
        coin(2'd0);
        coin(2'd3);
        chk("t5_reject",  32'(coin_reject), 1);
        chk("t5_credit",  32'(credit), 1);
        step();
        chk("t5_reject_off", 32'(coin_reject), 0);
        chk("t5_credit2",    32'(credit), 1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("t5_refund_amt", 32'(change_amt), 1);
        change_ready = 1'b1;
        step();
        change_ready = 1'b0;
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("t5_c0_chg_v",  32'(change_valid), 0);
        chk("t5_c0_ready",  32'(coin_ready), 1);
        chk("t5_c0_disp",   32'(dispense), 0);
        chk("t5_c0_credit", 32'(credit), 0);

        // 6: reset while change is pending
        coin(2'd1);
        coin(2'd1);
        coin(2'd1);
        step();
        chk("t6_pre_amt", 32'(change_amt), 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t6_chg_v",   32'(change_valid), 0);
        chk("t6_chg_amt", 32'(change_amt), 0);
        chk("t6_credit",  32'(credit), 0);
        chk("t6_disp",    32'(dispense), 0);
        chk("t6_reject",  32'(coin_reject), 0);
        chk("t6_ready",   32'(coin_ready), 1);
`ifdef VEND_SALES_CNT_EN
        chk("t6_sales",   32'(sales_cnt), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
